// File: rtl/dcache_ctrl_if.sv
// Memory-stage data cache bus: CPU request/response side plus the
// line-wide single-outstanding main-memory handshake.
interface dcache_ctrl_if;
  logic         req_valid;
  logic         req_we;
  logic         req_byte;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         dhit;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_byte,
    input  addr,
    input  wdata,
    input  mem_rdata,
    input  mem_ack,
    output rdata,
    output dhit,
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output req_valid,
    output req_we,
    output req_byte,
    output addr,
    output wdata,
    output mem_rdata,
    output mem_ack,
    input  rdata,
    input  dhit,
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache, 16-byte lines,
// stalls the pipeline through dhit while a line is written back or refilled.
module dcache_ctrl #(
  parameter int LINES = 4
) (
  input  logic         clk,
  input  logic         reset,
  dcache_ctrl_if.slave bus
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  logic [IW-1:0] miss_idx_q, miss_idx_d;
  logic [TW-1:0] wb_tag_q, wb_tag_d;
  logic [TW-1:0] rf_tag_q, rf_tag_d;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0]    wsel;
  logic          hit;

  logic [31:0] cur_word;
  logic [31:0] st_word;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [4:0]  shamt;

  logic          hit_store;
  logic          refill_done;
  logic          mem_req_c;
  logic          mem_we_c;
  logic [31:0]   mem_addr_c;
  logic [127:0]  mem_wdata_c;

  assign idx  = bus.addr[4 +: IW];
  assign tag  = bus.addr[31 -: TW];
  assign wsel = bus.addr[3:2];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);

  assign cur_word = data_q[idx][{wsel, 5'd0} +: 32];

  // Big-endian lanes: byte offset 0 lands in bits [31:24].
  assign shamt     = {~bus.addr[1:0], 3'b000};
  assign lane_mask = 32'h0000_00FF << shamt;
  assign lane_data = {24'd0, bus.wdata[7:0]} << shamt;
  assign st_word   = bus.req_byte
                   ? ((cur_word & ~lane_mask) | lane_data)
                   : bus.wdata;

  always_comb begin
    state_d     = state_q;
    miss_idx_d  = miss_idx_q;
    wb_tag_d    = wb_tag_q;
    rf_tag_d    = rf_tag_q;
    hit_store   = 1'b0;
    refill_done = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (hit) begin
            hit_store = bus.req_we;
          end else begin
            miss_idx_d = idx;
            wb_tag_d   = tag_q[idx];
            rf_tag_d   = tag;
            state_d    = (valid_q[idx] && dirty_q[idx])
                       ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = {wb_tag_q, miss_idx_q, 4'b0000};
        mem_wdata_c = data_q[miss_idx_q];
        if (bus.mem_ack) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req_c  = 1'b1;
        mem_addr_c = {rf_tag_q, miss_idx_q, 4'b0000};
        if (bus.mem_ack) begin
          refill_done = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_idx_q <= '0;
      wb_tag_q   <= '0;
      rf_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      miss_idx_q <= miss_idx_d;
      wb_tag_q   <= wb_tag_d;
      rf_tag_q   <= rf_tag_d;
      if (hit_store) begin
        dirty_q[idx] <= 1'b1;
      end
      if (refill_done) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
    end
  end

  // Arrays carry no reset; a reset still blocks any pending install.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (hit_store) begin
        data_q[idx][{wsel, 5'd0} +: 32] <= st_word;
      end
      if (refill_done) begin
        data_q[miss_idx_q] <= bus.mem_rdata;
        tag_q[miss_idx_q]  <= rf_tag_q;
      end
    end
  end

  assign bus.rdata     = cur_word;
  assign bus.dhit      = !bus.req_valid || ((state_q == IDLE) && hit);
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed accesses, a latency-2 memory
// responder, and a monitor checking CPU completions and memory transactions.
module tb_dcache_ctrl;
  typedef struct {
    logic        load;
    logic [31:0] data;
  } cpu_exp_t;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  logic clk;
  logic reset;
  logic stray;
  int   ack_dly;
  int   n_checks;
  int   n_errors;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  logic [127:0] mem [logic [31:0]];

  dcache_ctrl_if bus ();

  dcache_ctrl #(
    .LINES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm,
                              logic [127:0] act,
                              logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void bad(string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s", nm);
  endfunction

  task automatic exp_mem(input logic we,
                         input logic [31:0] a,
                         input logic [127:0] d);
    mem_exp_t e;
    e.we    = we;
    e.addr  = a;
    e.wdata = d;
    mem_q.push_back(e);
  endtask

  task automatic access(input logic we,
                        input logic bt,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [31:0] exp_rd,
                        input int exp_st);
    cpu_exp_t e;
    int st;
    e.load = !we;
    e.data = exp_rd;
    cpu_q.push_back(e);
    @(posedge clk);
    #2;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_byte  = bt;
    bus.addr      = a;
    bus.wdata     = d;
    st = 0;
    forever begin
      @(negedge clk);
      if (bus.dhit) break;
      st++;
      if (st > 60) begin
        bad("access_timeout");
        break;
      end
    end
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    chk("stall", 128'(st), 128'(exp_st));
  endtask

  // Memory responder: acks ack_dly cycles after mem_req is first seen.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = stray;
      if (stray) bus.mem_rdata = {4{32'hBADBAD00}};
      if (bus.mem_req) begin
        if (cnt == ack_dly) begin
          bus.mem_ack = 1'b1;
          cnt = 0;
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem[bus.mem_addr];
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops expectations as the DUT presents completions.
  initial begin
    logic prev_req;
    logic prev_ack;
    cpu_exp_t ce;
    mem_exp_t me;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus.req_valid && bus.dhit) begin
        if (cpu_q.size() == 0) begin
          bad("cpu_unexpected");
        end else begin
          ce = cpu_q.pop_front();
          if (ce.load) chk("rdata", 128'(bus.rdata), 128'(ce.data));
        end
      end
      if (bus.mem_req && (!prev_req || prev_ack)) begin
        if (mem_q.size() == 0) begin
          bad("mem_unexpected");
        end else begin
          me = mem_q.pop_front();
          chk("mem_we", 128'(bus.mem_we), 128'(me.we));
          chk("mem_addr", 128'(bus.mem_addr), 128'(me.addr));
          if (me.we) chk("mem_wdata", bus.mem_wdata, me.wdata);
        end
      end
      prev_req = bus.mem_req;
      prev_ack = bus.mem_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;
    n_checks = 0;
    n_errors = 0;
    ack_dly  = 2;
    stray    = 1'b0;
    reset    = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_byte  = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    mem[32'h100] = {32'h11111111, 32'h22222222,
                    32'h33333333, 32'h44444444};
    mem[32'h140] = {32'h55555555, 32'h66666666,
                    32'h77777777, 32'h88888888};
    mem[32'h200] = {32'h99999999, 32'hAAAAAAAA,
                    32'hBBBBBBBB, 32'hCCCCCCCC};

    repeat (3) @(negedge clk);
    chk("rst_dhit", 128'(bus.dhit), 128'd1);
    chk("rst_mem_req", 128'(bus.mem_req), 128'd0);
    chk("rst_mem_we", 128'(bus.mem_we), 128'd0);
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 128'd0);
    reset = 1'b0;

    exp_mem(1'b0, 32'h100, '0);
    access(1'b0, 1'b0, 32'h100, 32'h0, 32'h44444444, 4);
    access(1'b0, 1'b0, 32'h108, 32'h0, 32'h22222222, 0);
    access(1'b1, 1'b1, 32'h101, 32'h000000AB, 32'h0, 0);
    access(1'b0, 1'b0, 32'h100, 32'h0, 32'h44AB4444, 0);

    exp_mem(1'b1, 32'h100, {32'h11111111, 32'h22222222,
                            32'h33333333, 32'h44AB4444});
    exp_mem(1'b0, 32'h140, '0);
    access(1'b0, 1'b0, 32'h140, 32'h0, 32'h88888888, 7);

    @(posedge clk);
    #2;
    stray = 1'b1;
    @(posedge clk);
    #2;
    stray = 1'b0;
    @(negedge clk);
    chk("stray_ack", 128'(bus.mem_ack), 128'd1);
    chk("stray_dhit", 128'(bus.dhit), 128'd1);
    chk("stray_req", 128'(bus.mem_req), 128'd0);
    @(negedge clk);
    chk("stray_req2", 128'(bus.mem_req), 128'd0);
    access(1'b0, 1'b0, 32'h140, 32'h0, 32'h88888888, 0);

    exp_mem(1'b0, 32'h200, '0);
    @(posedge clk);
    #2;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_byte  = 1'b0;
    bus.addr      = 32'h200;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_ack_seen", 128'(ok), 128'd1);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_req", 128'(bus.mem_req), 128'd0);
    chk("rst_mid_dhit", 128'(bus.dhit), 128'd1);
    reset = 1'b0;

    exp_mem(1'b0, 32'h100, '0);
    access(1'b0, 1'b0, 32'h100, 32'h0, 32'h44AB4444, 4);
    exp_mem(1'b0, 32'h140, '0);
    access(1'b0, 1'b0, 32'h14C, 32'h0, 32'h55555555, 4);
    exp_mem(1'b0, 32'h100, '0);
    access(1'b1, 1'b0, 32'h10C, 32'hDEADBEEF, 32'h0, 4);
    exp_mem(1'b1, 32'h100, {32'hDEADBEEF, 32'h22222222,
                            32'h33333333, 32'h44AB4444});
    exp_mem(1'b0, 32'h140, '0);
    access(1'b0, 1'b0, 32'h14C, 32'h0, 32'h55555555, 7);
    exp_mem(1'b0, 32'h100, '0);
    access(1'b0, 1'b0, 32'h10C, 32'h0, 32'hDEADBEEF, 4);

    repeat (3) @(negedge clk);
    chk("cpu_q_empty", 128'(cpu_q.size()), 128'd0);
    chk("mem_q_empty", 128'(mem_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache for the pipelined processor's memory stage. It takes the M-stage address and store data, returns the load word to the M/W pipeline register, and drives `dhit` low to freeze the whole pipeline while a line is written back or refilled. On the far side it talks to main memory through a single-outstanding, line-wide req/ack handshake.

## Interface
- `LINES`, default 4: number of cache lines; power of two, ≥2. Line = 16 bytes (4 words).
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  M stage holds a load or store.
- `req_we`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  store is a byte store (loads always return the full word).
- `addr`  in  32  byte address (ALUOutM).
- `wdata`  in  32  store data (WriteDataM); byte stores use `wdata[7:0]`.
- `rdata`  out  32  load word (ReadData), combinational from the array.
- `dhit`  out  1  1 = access done / no stall; 0 = freeze pipeline.
- `mem_req`  out  1  memory transaction active.
- `mem_we`  out  1  1 = line write-back, 0 = line fetch.
- `mem_addr`  out  32  line-aligned address (`[3:0]` = 0).
- `mem_wdata`  out  128  line being written back.
- `mem_rdata`  in  128  refill line, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle completion pulse.

## Operation
- Address split: offset `addr[3:0]`, word `addr[3:2]`, index `addr[4+log2(LINES)-1:4]`, tag = remaining upper bits.
- Per line: valid, dirty, tag, 128-bit data; word k occupies bits `[32k+31:32k]`.
- Byte lanes are big-endian within a word: `addr[1:0]`=0 → bits `[31:24]`, 3 → bits `[7:0]`. `addr[1:0]` ignored for word accesses.
- hit = valid & tag match at index.
- `dhit` = !req_valid | (state==IDLE & hit).
- States:
  - IDLE: on req_valid & hit, a load returns `rdata` the same cycle; a store updates the word/byte lane at the edge and sets dirty. On req_valid & miss, go to WRITEBACK if the victim is valid & dirty, else REFILL.
  - WRITEBACK: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index, 4'b0}, `mem_wdata`=victim line. On `mem_ack` → REFILL.
  - REFILL: `mem_req`=1, `mem_we`=0, `mem_addr`={addr[31:4], 4'b0}. On `mem_ack`, write `mem_rdata`, set valid, set tag, clear dirty → IDLE.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from the registered state only (no combinational path from `addr` to `mem_req`).
- The pipeline holds `addr`/`req_*` stable while `dhit`=0, so the retried access hits in IDLE. A started transaction always runs to completion even if `req_valid` falls.
- `mem_ack` outside WRITEBACK/REFILL is ignored.
- A miss never modifies the victim line before write-back completes.

## Timing
- Reset: all valid/dirty bits = 0, state = IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `dhit`=1 (req_valid low). Data/tag arrays are not cleared.
- Hit: zero stall cycles. Store write takes effect at the same edge.
- Clean miss detected in cycle N: `mem_req` rises at N+1; `mem_ack` at N+1+L; line installed at that edge; hit with `dhit`=1 at N+2+L. Stall = L+2 cycles.
- Dirty miss: write-back ack at N+1+Lw, refill `mem_req` continues at N+2+Lw without a gap; stall = Lw+Lr+3.
- Reset mid-transaction: state returns to IDLE and `mem_req`=0 in the following cycle; the partial transaction is abandoned.
- `mem_ack` and reset in the same cycle: reset wins; no line is installed.

## Test plan
- Reset, then load 0x100; memory acks 2 cycles after `mem_req`, `mem_rdata`={0x11111111,0x22222222,0x33333333,0x44444444} → `mem_addr`=0x100, `mem_we`=0, `dhit` low 4 cycles, then `rdata`=0x44444444. Next, load 0x108 → same-cycle hit, `rdata`=0x22222222, no `mem_req`.
- Byte store 0x101, `wdata`=0x000000AB → no memory traffic, `dhit`=1; load 0x100 → 0x44AB4444.
- Load 0x140 (same index, new tag) → write-back with `mem_we`=1, `mem_addr`=0x100, `mem_wdata` word0 = 0x44AB4444; then refill from `mem_addr`=0x140; the load completes after both acks.
- Assert reset during REFILL of 0x200 with ack pending → `mem_req`=0 next cycle; a later load 0x100 misses (all lines invalid).
- `req_valid`=0 with a stray `mem_ack` pulse → `dhit`=1, `mem_req`=0, no array change.
- Store word 0x10C `wdata`=0xDEADBEEF on a miss to a clean line → refill, then store applied; line dirty; a later conflict load 0x14C writes back with word3=0xDEADBEEF.
